imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 32, number of 8-bit instruction words stored (power of two, max 256).
REQ-002 Parameter: FILL, 8'h00, instruction word returned for any address not holding a loaded word.
REQ-003 Port: clk_in  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port: clr  input  1  asynchronous, active-low reset.
REQ-005 Port: load_start  input  1  request to begin (or restart) program loading.
REQ-006 Port: load_valid  input  1  load_data holds a valid instruction word.
REQ-007 Port: load_data  input  8  instruction word being loaded.
REQ-008 Port: load_last  input  1  qualifies load_data as the final word of the program.
REQ-009 Port: load_ready  output  1  block accepts a load word this cycle.
REQ-010 Port: read_addr  input  8  instruction fetch address supplied by the processor.
REQ-011 Port: instruction  output  8  registered instruction word for read_addr.
REQ-012 Port: cpu_run  output  1  high only in RUN; processor is held idle while low.
REQ-013 Port: prog_len  output  9  number of words in the current program (0..DEPTH).
REQ-014 Port: overflow  output  1  program truncated at DEPTH words without load_last.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, LOAD, RUN.
REQ-016 IDLE: load_ready=0, cpu_run=0; load_start=1 SHALL move to LOAD next cycle, clearing write pointer, prog_len and overflow.
REQ-017 LOAD: load_ready SHALL be 1; a word is accepted only on a cycle with load_valid=1 and load_ready=1.
REQ-018 An accepted word SHALL be written to mem[wr_ptr] and wr_ptr SHALL increment by 1; prog_len SHALL equal the number of words accepted so far.
REQ-019 Accepting a word with load_last=1 SHALL move the FSM to RUN on the next cycle.
REQ-020 Accepting a word at wr_ptr=DEPTH-1 with load_last=0 SHALL store it, set prog_len=DEPTH, set overflow=1 and move to RUN.
REQ-021 load_valid=0 in LOAD SHALL stall with no state change; load_start in LOAD SHALL be ignored.
REQ-022 RUN: cpu_run=1, load_ready=0; load_valid SHALL be ignored.
REQ-023 load_start=1 in RUN SHALL move to LOAD next cycle (cpu_run=0 from that cycle) with REQ-016 clears applied.
REQ-024 In RUN, instruction SHALL update every cycle with 1-cycle latency: mem[read_addr] if read_addr (full 8 bits, unsigned) < prog_len, else FILL.
REQ-025 read_addr=8'hFF (processor counter at 0, minus 1) SHALL return FILL for any DEPTH < 256.
REQ-026 In IDLE and LOAD, instruction SHALL be FILL.
REQ-027 An empty program SHALL be impossible: minimum prog_len in RUN is 1.

Reset
REQ-028 clr=0 SHALL immediately force IDLE, load_ready=0, cpu_run=0, instruction=FILL, prog_len=0, overflow=0, wr_ptr=0, independent of clk_in.
REQ-029 Memory contents SHALL not be reset; after reset they are unreadable until reloaded (prog_len=0 masks them to FILL).
REQ-030 Reset asserted mid-LOAD SHALL discard the partial program; release SHALL return to IDLE, not LOAD.

Verification
REQ-031 Load 8'h41,8'h52,8'h93 (last on third), read_addr=0,1,2,3 -> instruction 8'h41,8'h52,8'h93,8'h00 each one cycle after address; prog_len=3, overflow=0, cpu_run=1.
REQ-032 Load with load_valid toggling 1,0,0,1 (two words, last on second) -> exactly two writes, prog_len=2, RUN entered cycle after second accept.
REQ-033 Stream 33 words, load_last never set, DEPTH=32 -> word 32 accepted, overflow=1, prog_len=32, load_ready=0 when word 33 presented; read_addr=31 returns word 32.
REQ-034 In RUN with prog_len=3, pulse load_start, load single word 8'hC1 with last -> cpu_run low for the LOAD period, then prog_len=1, read_addr=1 returns 8'h00.
REQ-035 Drive clr=0 asynchronously mid-LOAD after 2 words -> outputs reset without a clock edge; after release state IDLE, prog_len=0, read_addr=0 returns FILL.
REQ-036 In RUN, read_addr=8'hFF and 8'h20 -> instruction 8'h00.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: instruction memory with a streaming program loader.
//
// Accepts a program as a stream of 8-bit words while the processor is held idle,
// then releases the processor and serves registered instruction fetches.
// Addresses beyond the loaded program length read back as FILL.
//
// Ports
//   clk_in       system clock, rising edge
//   clr          asynchronous active-low reset
//   load_start   begin or restart program loading (from IDLE or RUN)
//   load_valid   load_data carries a word
//   load_data    instruction word being loaded
//   load_last    current word is the final word of the program
//   load_ready   loader accepts a word this cycle (LOAD only)
//   read_addr    processor fetch address
//   instruction  registered fetch result, one cycle after read_addr
//   cpu_run      processor may execute (RUN only)
//   prog_len     number of words in the current program, 0..DEPTH
//   overflow     program was cut at DEPTH words without seeing load_last

module imem_loader #(
    parameter int unsigned     DEPTH = 32,
    parameter logic [7:0]      FILL  = 8'h00
) (
    input  logic        clk_in,
    input  logic        clr,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [7:0]  read_addr,
    output logic [7:0]  instruction,
    output logic        cpu_run,
    output logic [8:0]  prog_len,
    output logic        overflow
);

    // state | meaning
    // ------+-----------------------------------------------------------
    // IDLE  | after reset; nothing loaded, processor held, fetches = FILL
    // LOAD  | accepting program words, processor held, fetches = FILL
    // RUN   | program resident, processor running, fetches served
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned      AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]    LAST_PTR = AW'(DEPTH - 1);

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     wr_ptr;
    logic [7:0]        mem [DEPTH];

    logic              accept;
    logic              at_end;
    logic              restart;
    logic              in_range;

    assign load_ready = (state == LOAD);
    assign cpu_run    = (state == RUN);
    assign accept     = load_valid && load_ready;
    assign at_end     = (wr_ptr == LAST_PTR);
    // load_start only restarts from IDLE/RUN; it is ignored mid-load
    assign restart    = load_start && (state != LOAD);
    // full 8-bit compare so 8'hFF and other out-of-program addresses mask to FILL
    assign in_range   = ({1'b0, read_addr} < prog_len);

    always_ff @(posedge clk_in or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept && (load_last || at_end)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_next = LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge clr) begin
        if (!clr) begin
            wr_ptr      <= '0;
            prog_len    <= '0;
            overflow    <= 1'b0;
            instruction <= FILL;
        end else begin
            if (restart) begin
                wr_ptr   <= '0;
                prog_len <= '0;
                overflow <= 1'b0;
            end else if (accept) begin
                wr_ptr   <= wr_ptr + AW'(1);
                prog_len <= prog_len + 9'd1;
                if (at_end && !load_last) begin
                    overflow <= 1'b1;
                end
            end

            if ((state == RUN) && in_range) begin
                instruction <= mem[read_addr[AW-1:0]];
            end else begin
                instruction <= FILL;
            end
        end
    end

    // storage is deliberately not reset; prog_len masks stale contents
    always_ff @(posedge clk_in) begin
        if (accept) begin
            mem[wr_ptr] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (DEPTH=32, FILL=8'h00).
//
// Inputs are driven and outputs sampled 1 time unit after each rising clock
// edge. Every expected value below is hand-derived from the block's behaviour.

module tb_imem_loader;

    logic        clk_in;
    logic        clr;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic [7:0]  read_addr;
    logic [7:0]  instruction;
    logic        cpu_run;
    logic [8:0]  prog_len;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    imem_loader #(
        .DEPTH (32),
        .FILL  (8'h00)
    ) dut (
        .clk_in      (clk_in),
        .clr         (clr),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .read_addr   (read_addr),
        .instruction (instruction),
        .cpu_run     (cpu_run),
        .prog_len    (prog_len),
        .overflow    (overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clr        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        read_addr  = 8'h00;

        // asynchronous reset, no clock edge in between
        #3 clr = 1'b0;
        #1;
        chk("rst_ready",   16'(load_ready),  16'h0);
        chk("rst_run",     16'(cpu_run),     16'h0);
        chk("rst_len",     16'(prog_len),    16'h0);
        chk("rst_ovf",     16'(overflow),    16'h0);
        chk("rst_instr",   16'(instruction), 16'h00);
        #10 clr = 1'b1;
        step();
        chk("idle_ready",  16'(load_ready),  16'h0);

        // three-word program 41,52,93
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("load_ready",  16'(load_ready),  16'h1);
        chk("load_run",    16'(cpu_run),     16'h0);
        chk("load_len0",   16'(prog_len),    16'h0);
        load_valid = 1'b1; load_data = 8'h41; step();
        load_data = 8'h52; step();
        load_data = 8'h93; load_last = 1'b1; step();
        load_valid = 1'b0; load_last = 1'b0;
        chk("p3_run",      16'(cpu_run),     16'h1);
        chk("p3_ready",    16'(load_ready),  16'h0);
        chk("p3_len",      16'(prog_len),    16'h3);
        chk("p3_ovf",      16'(overflow),    16'h0);
        chk("p3_instr_ld", 16'(instruction), 16'h00);
        read_addr = 8'h00; step(); chk("p3_rd0",  16'(instruction), 16'h41);
        read_addr = 8'h01; step(); chk("p3_rd1",  16'(instruction), 16'h52);
        read_addr = 8'h02; step(); chk("p3_rd2",  16'(instruction), 16'h93);
        read_addr = 8'h03; step(); chk("p3_rd3",  16'(instruction), 16'h00);
        read_addr = 8'hFF; step(); chk("p3_rdFF", 16'(instruction), 16'h00);
        read_addr = 8'h20; step(); chk("p3_rd20", 16'(instruction), 16'h00);

        // restart from RUN with a single-word program
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("rl_run",      16'(cpu_run),     16'h0);
        chk("rl_ready",    16'(load_ready),  16'h1);
        chk("rl_len",      16'(prog_len),    16'h0);
        load_valid = 1'b1; load_data = 8'hC1; load_last = 1'b1; step();
        load_valid = 1'b0; load_last = 1'b0;
        chk("rl_run1",     16'(cpu_run),     16'h1);
        chk("rl_len1",     16'(prog_len),    16'h1);
        read_addr = 8'h01; step(); chk("rl_rd1", 16'(instruction), 16'h00);
        read_addr = 8'h00; step(); chk("rl_rd0", 16'(instruction), 16'hC1);

        // valid toggling 1,0,0,1 with ignored load_start during the stall
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 8'h11; step();
        load_valid = 1'b0; load_data = 8'h99; step();
        chk("st_len1",     16'(prog_len),    16'h1);
        chk("st_ready",    16'(load_ready),  16'h1);
        load_start = 1'b1; step();
        load_start = 1'b0;
        chk("st_ign_len",  16'(prog_len),    16'h1);
        chk("st_ign_st",   16'(load_ready),  16'h1);
        load_valid = 1'b1; load_data = 8'h22; load_last = 1'b1; step();
        load_last = 1'b0;
        // load_valid stays high in RUN and must be ignored
        load_data = 8'hEE;
        chk("st_run",      16'(cpu_run),     16'h1);
        chk("st_len2",     16'(prog_len),    16'h2);
        read_addr = 8'h00; step(); chk("st_rd0", 16'(instruction), 16'h11);
        read_addr = 8'h01; step(); chk("st_rd1", 16'(instruction), 16'h22);
        // mem[2] still holds 8'h93 from the first program; must be masked
        read_addr = 8'h02; step(); chk("st_rd2", 16'(instruction), 16'h00);
        chk("st_len_hold", 16'(prog_len),    16'h2);
        load_valid = 1'b0;

        // overflow: 33 words offered, no load_last
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            load_valid = 1'b1;
            load_data  = 8'h80 + 8'(i);
            step();
        end
        load_data = 8'hFE;
        chk("ov_ready",    16'(load_ready),  16'h0);
        chk("ov_flag",     16'(overflow),    16'h1);
        chk("ov_len",      16'(prog_len),    16'd32);
        chk("ov_run",      16'(cpu_run),     16'h1);
        read_addr = 8'd31; step(); chk("ov_rd31", 16'(instruction), 16'h9F);
        chk("ov_len_hold", 16'(prog_len),    16'd32);
        read_addr = 8'd32; step(); chk("ov_rd32", 16'(instruction), 16'h00);
        read_addr = 8'd0;  step(); chk("ov_rd0",  16'(instruction), 16'h80);
        load_valid = 1'b0;

        // async reset mid-load after two words
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        chk("ar_ovf_clr",  16'(overflow),    16'h0);
        load_valid = 1'b1; load_data = 8'hAA; step();
        load_data = 8'hBB; step();
        load_valid = 1'b0;
        chk("ar_len2",     16'(prog_len),    16'h2);
        #2 clr = 1'b0;
        #1;
        chk("ar_ready",    16'(load_ready),  16'h0);
        chk("ar_run",      16'(cpu_run),     16'h0);
        chk("ar_len",      16'(prog_len),    16'h0);
        chk("ar_instr",    16'(instruction), 16'h00);
        #2 clr = 1'b1;
        read_addr = 8'h00;
        step();
        chk("ar_idle_rdy", 16'(load_ready),  16'h0);
        chk("ar_idle_run", 16'(cpu_run),     16'h0);
        chk("ar_idle_len", 16'(prog_len),    16'h0);
        step();
        chk("ar_rd0",      16'(instruction), 16'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
